load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Parametrised successor to the single-cycle data memory port: executes RV loads/stores (LB/LH/LW/LBU/LHU, SB/SH/SW; LD/LWU/SD when DATA_W=64) over a multi-cycle req/gnt/rvalid memory interface.
- Performs lane steering, byte strobes and sign/zero extension.
- Sits between the EXU and the data memory/bus adapter.
- Handshakes with the core through valid/ready so the core stalls while an access is outstanding.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data/register width; legal values 32 or 64.
- STRB_W, DATA_W/8, byte-strobe width (derived, localparam).

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  access request from core
- in_ready  out  1  LSU can accept request (high only in IDLE)
- in_is_store  in  1  1=store, 0=load
- in_funct3  in  3  RV funct3 (size/sign)
- in_addr  in  ADDR_W  effective byte address
- in_wdata  in  DATA_W  store data, right-aligned
- out_valid  out  1  one-cycle completion pulse
- out_rdata  out  DATA_W  extended load data (0 for stores/errors)
- out_err  out  1  access failed (misaligned/illegal funct3), valid with out_valid
- mem_req  out  1  memory request, held until mem_gnt
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  bus-aligned address (low log2(STRB_W) bits zero)
- mem_wstrb  out  STRB_W  byte-lane strobes
- mem_wdata  out  DATA_W  lane-shifted store data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  response (read data or write ack)
- mem_rdata  in  DATA_W  bus-aligned read data

Behaviour:
- Reset (async, rst=1): state=IDLE; in_ready=1; out_valid=0, out_err=0, out_rdata=0; mem_req=0, mem_we=0, mem_addr=0, mem_wstrb=0, mem_wdata=0; captured request registers cleared.
- States IDLE, REQ, WAIT, DONE.
- IDLE:
  - in_valid accepted → capture funct3/is_store/addr/wdata.
  - Legal access → REQ, with mem_* driven from the registers in the following cycle.
  - Illegal access → DONE with err=1; no memory request is issued.
- REQ:
  - mem_req=1; mem_addr, mem_we, mem_wstrb and mem_wdata held stable until mem_gnt.
  - mem_gnt & !mem_rvalid → WAIT.
  - mem_gnt & mem_rvalid in the same cycle → DONE; data is captured in that cycle.
- WAIT: mem_req=0; on mem_rvalid, capture mem_rdata and go to DONE.
- DONE: out_valid=1 for exactly one cycle, then IDLE. in_ready=0 in DONE, so minimum latency from acceptance to out_valid is 3 cycles with zero-wait memory.
- Offset off = addr[log2(STRB_W)-1:0].
- Strobes: byte = 1<<off; half = 3<<off; word = 0xF<<off; dword = all ones.
- Store data: mem_wdata = in_wdata << (8*off).
- Load: shifted = mem_rdata >> (8*off), then extended per funct3:
  - 000 → sign-extend 8 bits; 100 → zero-extend 8 bits.
  - 001 → sign-extend 16 bits; 101 → zero-extend 16 bits.
  - 010 → sign-extend 32 bits; 110 → zero-extend 32 bits (64-bit only).
  - 011 → full 64 bits (64-bit only).
- Illegal funct3:
  - Loads: 111; 011 and 110 when DATA_W=32.
  - Stores: 1xx; 011 when DATA_W=32.
  - Result: out_err=1, out_rdata=0, no bus activity.
- Stores: out_valid when the write-ack mem_rvalid arrives; out_rdata=0.
- mem_rvalid outside REQ/WAIT (e.g. a stale response after reset) is ignored.
- mem_gnt while mem_req=0 is ignored.
- Reset mid-access aborts to IDLE; no out_valid is generated.
- Misalignment (half with off[0]=1, word with off[1:0]≠0, dword with off≠0):
  - Behaviour depends on the optional feature below.
  - An access crossing a bus word is never split.

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined: a misaligned access completes via IDLE→DONE with out_err=1, out_rdata=0 and no mem_req.
- LSU_MISALIGN_TRAP_EN undefined: the offset is truncated to natural alignment (low bits forced to zero per size) and the access proceeds normally with out_err=0.

Decomposition:
- Shared package lsu_pkg holds:
  - the state enum;
  - funct3 constants (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU);
  - a function size_of(funct3) and a function legal(funct3, is_store, DATA_W).
- Sub-module lsu_load_align (combinational: mem_rdata, off, funct3 → extended out_rdata) is natural and tested stand-alone.
- Strobe/wdata generation stays inline.

Test Plan:
- DATA_W=32, LB @0x1003, memory word 0x80FF1234, zero-wait gnt/rvalid → out_rdata=0xFFFFFF80, out_valid 3 cycles after acceptance, mem_addr=0x1000.
- SH 0xABCD @0x2002, gnt delayed 2 cycles → mem_req held 3 cycles with mem_wstrb=0b1100, mem_wdata=0xABCD0000 stable; out_valid after ack.
- LHU @0x3002, mem_gnt and mem_rvalid in the same cycle returning 0xBEEF0000 → REQ→DONE directly, out_rdata=0x0000BEEF.
- LW @0x4001 with LSU_MISALIGN_TRAP_EN → no mem_req, out_err=1, out_rdata=0. Without the macro → mem_addr=0x4000, mem_wstrb=0xF, out_err=0.
- Load with funct3=111 → out_err=1, no mem_req. DATA_W=64 LD @0x8 with rdata 0x8000_0000_0000_0001 → out_rdata unchanged.
- rst asserted in WAIT, then mem_rvalid arrives after rst release → no out_valid, in_ready=1, all outputs at reset values.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RV funct3
// encodings, access-size decode and funct3 legality per data width.
package lsu_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   // log2 of the access size in bytes: 0=byte, 1=half, 2=word, 3=dword
   function automatic logic [1:0] size_of(input logic [2:0] funct3);
      return funct3[1:0];
   endfunction

   function automatic logic legal(input logic [2:0] funct3, input logic is_store,
                                  input int data_w);
      logic ok;
      if (is_store) begin
         ok = (funct3[2] == 1'b0) && ((funct3 != F3_D) || (data_w == 32'sd64));
      end else begin
         ok = (funct3 != 3'b111) &&
              !((data_w == 32'sd32) && ((funct3 == F3_D) || (funct3 == F3_WU)));
      end
      return ok;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load-data steering: shifts the bus-aligned read word down by the byte
// offset and sign/zero-extends it according to funct3.
module lsu_load_align
   import lsu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]                mem_rdata,
   input  logic [$clog2(DATA_W/8)-1:0]      off,
   input  logic [2:0]                       funct3,
   output logic [DATA_W-1:0]                rdata_ext
);

   logic [DATA_W-1:0] shifted_s;

   // Lane shift followed by size/sign extension
   always_comb begin
      shifted_s = mem_rdata >> {off, 3'b000};
      case (funct3)
         F3_B:    rdata_ext = DATA_W'(signed'(shifted_s[7:0]));
         F3_BU:   rdata_ext = DATA_W'(shifted_s[7:0]);
         F3_H:    rdata_ext = DATA_W'(signed'(shifted_s[15:0]));
         F3_HU:   rdata_ext = DATA_W'(shifted_s[15:0]);
         F3_W:    rdata_ext = DATA_W'(signed'(shifted_s[31:0]));
         F3_WU:   rdata_ext = DATA_W'(shifted_s[31:0]);
         F3_D:    rdata_ext = shifted_s;
         default: rdata_ext = '0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV load/store unit over a req/gnt/rvalid memory port. Define
// LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of truncating them.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_is_store,
   input  logic [2:0]             in_funct3,
   input  logic [ADDR_W-1:0]      in_addr,
   input  logic [DATA_W-1:0]      in_wdata,
   output logic                   out_valid,
   output logic [DATA_W-1:0]      out_rdata,
   output logic                   out_err,
   output logic                   mem_req,
   output logic                   mem_we,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic [DATA_W/8-1:0]    mem_wstrb,
   output logic [DATA_W-1:0]      mem_wdata,
   input  logic                   mem_gnt,
   input  logic                   mem_rvalid,
   input  logic [DATA_W-1:0]      mem_rdata
);

   localparam int STRB_W = DATA_W / 8;
   localparam int OFF_W  = $clog2(STRB_W);

   lsu_state_e         state_r;
   logic [2:0]         f3_r;
   logic               store_r;
   logic [OFF_W-1:0]   off_r;

   logic [1:0]         size_s;
   logic [OFF_W-1:0]   off_s;
   logic [OFF_W-1:0]   mask_s;
   logic [OFF_W-1:0]   off_eff_s;
   logic               acc_err_s;
   logic [ADDR_W-1:0]  addr_al_s;
   logic [STRB_W-1:0]  strb_s;
   logic [DATA_W-1:0]  wdata_s;
   logic [DATA_W-1:0]  load_data_s;

   // Request decode: alignment, legality, strobes and store-lane steering
   always_comb begin
      size_s    = size_of(in_funct3);
      off_s     = in_addr[OFF_W-1:0];
      mask_s    = OFF_W'((4'd1 << size_s) - 4'd1);
      off_eff_s = off_s & ~mask_s;
`ifdef LSU_MISALIGN_TRAP_EN
      acc_err_s = !legal(in_funct3, in_is_store, DATA_W) || ((off_s & mask_s) != '0);
`else
      acc_err_s = !legal(in_funct3, in_is_store, DATA_W);
`endif
      addr_al_s = {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      case (size_s)
         2'd0:    strb_s = STRB_W'(4'h1) << off_eff_s;
         2'd1:    strb_s = STRB_W'(4'h3) << off_eff_s;
         2'd2:    strb_s = STRB_W'(4'hF) << off_eff_s;
         2'd3:    strb_s = '1;
         default: strb_s = '0;
      endcase
      wdata_s = in_wdata << {off_eff_s, 3'b000};
   end

   lsu_load_align #(.DATA_W(DATA_W)) u_load_align (
      .mem_rdata (mem_rdata),
      .off       (off_r),
      .funct3    (f3_r),
      .rdata_ext (load_data_s)
   );

   // Access FSM; every core- and bus-facing output is a register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= S_IDLE;
         f3_r      <= 3'b000;
         store_r   <= 1'b0;
         off_r     <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_err   <= 1'b0;
         out_rdata <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wstrb <= '0;
         mem_wdata <= '0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  f3_r     <= in_funct3;
                  store_r  <= in_is_store;
                  off_r    <= off_eff_s;
                  in_ready <= 1'b0;
                  if (acc_err_s) begin
                     state_r   <= S_DONE;
                     out_valid <= 1'b1;
                     out_err   <= 1'b1;
                     out_rdata <= '0;
                  end else begin
                     state_r   <= S_REQ;
                     mem_req   <= 1'b1;
                     mem_we    <= in_is_store;
                     mem_addr  <= addr_al_s;
                     mem_wstrb <= strb_s;
                     mem_wdata <= wdata_s;
                  end
               end
            end
            S_REQ: begin
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  if (mem_rvalid) begin
                     state_r   <= S_DONE;
                     out_valid <= 1'b1;
                     out_err   <= 1'b0;
                     out_rdata <= store_r ? '0 : load_data_s;
                  end else begin
                     state_r <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (mem_rvalid) begin
                  state_r   <= S_DONE;
                  out_valid <= 1'b1;
                  out_err   <= 1'b0;
                  out_rdata <= store_r ? '0 : load_data_s;
               end
            end
            S_DONE: begin
               state_r   <= S_IDLE;
               out_valid <= 1'b0;
               out_err   <= 1'b0;
               in_ready  <= 1'b1;
            end
            default: begin
               state_r   <= S_IDLE;
               out_valid <= 1'b0;
               out_err   <= 1'b0;
               mem_req   <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table over a scripted memory
// responder plus hand sequences for wait states, early response, reset and 64-bit.
module tb_load_store_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid, in_ready, in_is_store;
   logic [2:0]  in_funct3;
   logic [31:0] in_addr, in_wdata;
   logic        out_valid, out_err;
   logic [31:0] out_rdata;
   logic        mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;

   logic        v64, rdy64, st64, ov64, err64, req64, we64, gnt64, rv64;
   logic [2:0]  f3_64;
   logic [31:0] addr64, maddr64;
   logic [63:0] wd64, ord64, mwd64, mrd64;
   logic [7:0]  strb64;

   load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_is_store(in_is_store), .in_funct3(in_funct3), .in_addr(in_addr),
      .in_wdata(in_wdata), .out_valid(out_valid), .out_rdata(out_rdata),
      .out_err(out_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   load_store_unit #(.ADDR_W(32), .DATA_W(64)) dut64 (
      .clk(clk), .rst(rst), .in_valid(v64), .in_ready(rdy64),
      .in_is_store(st64), .in_funct3(f3_64), .in_addr(addr64),
      .in_wdata(wd64), .out_valid(ov64), .out_rdata(ord64),
      .out_err(err64), .mem_req(req64), .mem_we(we64), .mem_addr(maddr64),
      .mem_wstrb(strb64), .mem_wdata(mwd64), .mem_gnt(gnt64),
      .mem_rvalid(rv64), .mem_rdata(mrd64)
   );

   typedef struct {
      string       name;
      logic        st;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic [3:0]  exp_strb;
      logic [31:0] exp_wdata;
      int          exp_lat;
   } vec_t;

   vec_t vecs[16];
   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // One access on the 32-bit DUT; grant after gnt_dly request cycles, response
   // one cycle after grant unless same is set. r_lat = -1 if no completion seen.
   task automatic run_access(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rd,
                             input int gnt_dly, input bit same,
                             output logic [31:0] r_rdata, output logic r_err,
                             output bit r_req, output logic [31:0] r_addr,
                             output logic [3:0] r_strb, output logic [31:0] r_wdata,
                             output int r_lat, output int r_req_cyc, output bit r_stable);
      bit pend = 1'b0;
      r_req = 1'b0; r_stable = 1'b1; r_req_cyc = 0; r_lat = -1;
      r_rdata = 32'h0; r_err = 1'b0; r_addr = 32'h0; r_strb = 4'h0; r_wdata = 32'h0;
      @(negedge clk);
      in_valid = 1'b1; in_is_store = st; in_funct3 = f3; in_addr = addr; in_wdata = wd;
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
         if (out_valid) begin
            r_lat = k; r_rdata = out_rdata; r_err = out_err;
            break;
         end
         if (mem_req) begin
            r_req_cyc++;
            if (!r_req) begin
               r_addr = mem_addr; r_strb = mem_wstrb; r_wdata = mem_wdata;
            end else if (r_addr !== mem_addr || r_strb !== mem_wstrb ||
                         r_wdata !== mem_wdata || mem_we !== st) begin
               r_stable = 1'b0;
            end
            r_req = 1'b1;
            if (r_req_cyc > gnt_dly) begin
               mem_gnt = 1'b1;
               if (same) begin mem_rvalid = 1'b1; mem_rdata = rd; end
               else pend = 1'b1;
            end
         end else if (pend) begin
            mem_rvalid = 1'b1; mem_rdata = rd; pend = 1'b0;
         end
         @(negedge clk);
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
   endtask

   task automatic run64(input string name, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [63:0] rd, input logic [31:0] exp_addr,
                        input logic [7:0] exp_strb, input logic [63:0] exp_rdata);
      @(negedge clk);
      v64 = 1'b1; st64 = 1'b0; f3_64 = f3; addr64 = addr; wd64 = 64'h0;
      @(negedge clk);
      v64 = 1'b0;
      check({name, "_req"}, {63'h0, req64}, 64'h1);
      check({name, "_addr"}, {32'h0, maddr64}, {32'h0, exp_addr});
      check({name, "_strb"}, {56'h0, strb64}, {56'h0, exp_strb});
      gnt64 = 1'b1;
      @(negedge clk);
      gnt64 = 1'b0; rv64 = 1'b1; mrd64 = rd;
      @(negedge clk);
      rv64 = 1'b0; mrd64 = 64'h0;
      check({name, "_valid"}, {63'h0, ov64}, 64'h1);
      check({name, "_rdata"}, ord64, exp_rdata);
   endtask

   logic [31:0] g_rdata, g_addr, g_wdata;
   logic        g_err;
   logic [3:0]  g_strb;
   bit          g_req, g_stable, seen;
   int          g_lat, g_req_cyc;

   initial begin
      vecs[0]  = '{"lb_neg",  1'b0, 3'b000, 32'h1003, 32'h0, 32'h80FF1234, 32'hFFFFFF80, 1'b0, 1'b1, 32'h1000, 4'h8, 32'h0, 3};
      vecs[1]  = '{"lbu",     1'b0, 3'b100, 32'h1003, 32'h0, 32'h80FF1234, 32'h00000080, 1'b0, 1'b1, 32'h1000, 4'h8, 32'h0, 3};
      vecs[2]  = '{"lh_neg",  1'b0, 3'b001, 32'h1002, 32'h0, 32'h80FF1234, 32'hFFFF80FF, 1'b0, 1'b1, 32'h1000, 4'hC, 32'h0, 3};
      vecs[3]  = '{"lhu_lo",  1'b0, 3'b101, 32'h1000, 32'h0, 32'h80FF1234, 32'h00001234, 1'b0, 1'b1, 32'h1000, 4'h3, 32'h0, 3};
      vecs[4]  = '{"lw",      1'b0, 3'b010, 32'h1004, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1, 32'h1004, 4'hF, 32'h0, 3};
      vecs[5]  = '{"lb_pos",  1'b0, 3'b000, 32'h1001, 32'h0, 32'h80FF1234, 32'h00000012, 1'b0, 1'b1, 32'h1000, 4'h2, 32'h0, 3};
      vecs[6]  = '{"sb",      1'b1, 3'b000, 32'h2001, 32'h000000A5, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b1, 32'h2000, 4'h2, 32'h0000A500, 3};
      vecs[7]  = '{"sw",      1'b1, 3'b010, 32'h2000, 32'h12345678, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b1, 32'h2000, 4'hF, 32'h12345678, 3};
      vecs[8]  = '{"ld_f3_7", 1'b0, 3'b111, 32'h0000, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1};
      vecs[9]  = '{"ld_f3_3", 1'b0, 3'b011, 32'h0008, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1};
      vecs[10] = '{"ld_f3_6", 1'b0, 3'b110, 32'h0010, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1};
      vecs[11] = '{"st_f3_4", 1'b1, 3'b100, 32'h0020, 32'hFF, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1};
      vecs[12] = '{"st_f3_3", 1'b1, 3'b011, 32'h0020, 32'hFF, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1};
`ifdef LSU_MISALIGN_TRAP_EN
      vecs[13] = '{"lw_mis",  1'b0, 3'b010, 32'h4001, 32'h0, 32'h11223344, 32'h0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1};
      vecs[14] = '{"lh_mis",  1'b0, 3'b001, 32'h4003, 32'h0, 32'hAABBCCDD, 32'h0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1};
      vecs[15] = '{"sh_mis",  1'b1, 3'b001, 32'h2003, 32'h1234, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1};
`else
      vecs[13] = '{"lw_mis",  1'b0, 3'b010, 32'h4001, 32'h0, 32'h11223344, 32'h11223344, 1'b0, 1'b1, 32'h4000, 4'hF, 32'h0, 3};
      vecs[14] = '{"lh_mis",  1'b0, 3'b001, 32'h4003, 32'h0, 32'hAABBCCDD, 32'hFFFFAABB, 1'b0, 1'b1, 32'h4000, 4'hC, 32'h0, 3};
      vecs[15] = '{"sh_mis",  1'b1, 3'b001, 32'h2003, 32'h1234, 32'h0, 32'h0, 1'b0, 1'b1, 32'h2000, 4'hC, 32'h12340000, 3};
`endif

      rst = 1'b1;
      in_valid = 1'b0; in_is_store = 1'b0; in_funct3 = 3'b000; in_addr = 32'h0; in_wdata = 32'h0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      v64 = 1'b0; st64 = 1'b0; f3_64 = 3'b000; addr64 = 32'h0; wd64 = 64'h0;
      gnt64 = 1'b0; rv64 = 1'b0; mrd64 = 64'h0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", {63'h0, in_ready}, 64'h1);
      check("rst_out_valid", {63'h0, out_valid}, 64'h0);
      check("rst_mem_req", {63'h0, mem_req}, 64'h0);
      check("rst_mem_addr", {32'h0, mem_addr}, 64'h0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         run_access(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wd, vecs[i].rd, 0, 1'b0,
                    g_rdata, g_err, g_req, g_addr, g_strb, g_wdata, g_lat, g_req_cyc, g_stable);
         check({vecs[i].name, "_rdata"}, {32'h0, g_rdata}, {32'h0, vecs[i].exp_rdata});
         check({vecs[i].name, "_err"}, {63'h0, g_err}, {63'h0, vecs[i].exp_err});
         check({vecs[i].name, "_req"}, {63'h0, g_req}, {63'h0, vecs[i].exp_req});
         check({vecs[i].name, "_lat"}, 64'(g_lat), 64'(vecs[i].exp_lat));
         if (vecs[i].exp_req) begin
            check({vecs[i].name, "_addr"}, {32'h0, g_addr}, {32'h0, vecs[i].exp_addr});
            check({vecs[i].name, "_strb"}, {60'h0, g_strb}, {60'h0, vecs[i].exp_strb});
            check({vecs[i].name, "_wdata"}, {32'h0, g_wdata}, {32'h0, vecs[i].exp_wdata});
         end
      end

      // SH with two wait cycles before grant
      run_access(1'b1, 3'b001, 32'h2002, 32'h0000ABCD, 32'h0, 2, 1'b0,
                 g_rdata, g_err, g_req, g_addr, g_strb, g_wdata, g_lat, g_req_cyc, g_stable);
      check("sh_wait_req_cycles", 64'(g_req_cyc), 64'd3);
      check("sh_wait_stable", {63'h0, g_stable}, 64'h1);
      check("sh_wait_strb", {60'h0, g_strb}, 64'hC);
      check("sh_wait_wdata", {32'h0, g_wdata}, 64'hABCD0000);
      check("sh_wait_lat", 64'(g_lat), 64'd5);
      check("sh_wait_rdata", {32'h0, g_rdata}, 64'h0);

      // LHU with grant and response in the same cycle
      run_access(1'b0, 3'b101, 32'h3002, 32'h0, 32'hBEEF0000, 0, 1'b1,
                 g_rdata, g_err, g_req, g_addr, g_strb, g_wdata, g_lat, g_req_cyc, g_stable);
      check("lhu_same_lat", 64'(g_lat), 64'd2);
      check("lhu_same_rdata", {32'h0, g_rdata}, 64'h0000BEEF);
      @(negedge clk);
      check("pulse_one_cycle", {63'h0, out_valid}, 64'h0);
      check("ready_after_done", {63'h0, in_ready}, 64'h1);

      // Reset while waiting for the response, then a stale response arrives
      in_valid = 1'b1; in_is_store = 1'b0; in_funct3 = 3'b010; in_addr = 32'h5000;
      @(negedge clk);
      in_valid = 1'b0; mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      check("wait_not_ready", {63'h0, in_ready}, 64'h0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'h12345678;
      seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         mem_rvalid = 1'b0; mem_gnt = 1'b0;
         if (out_valid || mem_req) seen = 1'b1;
      end
      check("abort_no_valid", {63'h0, seen}, 64'h0);
      check("abort_in_ready", {63'h0, in_ready}, 64'h1);
      check("abort_mem_we", {63'h0, mem_we}, 64'h0);
      check("abort_mem_addr", {32'h0, mem_addr}, 64'h0);
      check("abort_mem_wstrb", {60'h0, mem_wstrb}, 64'h0);
      check("abort_out_rdata", {32'h0, out_rdata}, 64'h0);
      check("abort_out_err", {63'h0, out_err}, 64'h0);

      run64("ld64", 3'b011, 32'h8, 64'h8000_0000_0000_0001, 32'h8, 8'hFF, 64'h8000_0000_0000_0001);
      @(negedge clk);
      run64("lwu64", 3'b110, 32'hC, 64'h8000_0001_0000_0000, 32'h8, 8'hF0, 64'h0000_0000_8000_0001);
      @(negedge clk);
      run64("lw64", 3'b010, 32'hC, 64'h8000_0001_0000_0000, 32'h8, 8'hF0, 64'hFFFF_FFFF_8000_0001);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
